spi_tx_export: RTL and testbench
================================

// Module: spi_tx_export
// PURPOSE
//  System-clock side of the SPI peripheral transmit path; the stage directly upstream of the SPI TX shifter.
//  Buffers bytes written by the Wishbone peripheral logic in a small FIFO.
//  Hands them one at a time across to the SCK domain over a toggle req/ack clock-domain handshake (cdc_data/cdc_req/cdc_ack).
//  The SCK-side importer latches cdc_data; the shifter repeats the last imported byte until a new one arrives.
// PARAMETERS
//  DEPTH   8   FIFO depth in bytes; power of 2, >= 2
//  LW      $clog2(DEPTH)+1   width of level output (derived, localparam)
// PORTS
//  clk       in   1    system clock; only clock of this block
//  rst_n     in   1    asynchronous, active-low reset
//  wr_stb    in   1    write strobe, one byte per cycle
//  wr_data   in   8    byte to transmit
//  wr_ready  out  1    FIFO not full
//  level     out  LW   bytes in FIFO, 0..DEPTH (excludes byte in flight)
//  overflow  out  1    sticky: a write was dropped because the FIFO was full
//  ovf_clr   in   1    clears overflow
//  cdc_data  out  8    byte presented to SCK domain; stable while handshake open
//  cdc_req   out  1    request toggle; toggles once per byte exported
//  cdc_ack   in   1    ack toggle from SCK domain, asynchronous to clk
// BEHAVIOUR
//  Reset (async assert, sync release): FIFO empty, level=0, wr_ready=1, overflow=0, cdc_data=8'h00, cdc_req=0, ack synchroniser=0, FSM=IDLE.
//  Write: wr_stb && wr_ready pushes wr_data at the clock edge.
//   wr_stb while full: byte dropped, overflow<=1. A pop in the same cycle does not rescue it; no write-through.
//  ovf_clr: overflow<=0; if a drop happens in the same cycle, set wins.
//  cdc_ack passes through a 2-FF synchroniser -> ack_s. cdc_ack is never used unsynchronised.
//  FSM:
//   IDLE -> LOAD: when FIFO non-empty; cdc_data<=head, pop (level-1).
//   LOAD -> WAIT: cdc_req<=~cdc_req. Data is settled one cycle before req toggles.
//   WAIT -> IDLE: when ack_s==cdc_req.
//  cdc_data is held constant from LOAD until the next LOAD.
//  Latency: write at edge N into an empty FIFO with FSM in IDLE:
//   cdc_data valid after edge N+1;
//   cdc_req toggles at edge N+2.
//  Throughput: one byte per (3 + ack round trip) clk cycles. Back-to-back writes queue in the FIFO.
//  Simultaneous push+pop: both take effect; level unchanged.
//  Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty come from level, never from pointer equality alone.
//  Empty FIFO: no handshake is started. cdc_data keeps the last byte, which the shifter keeps repeating.
//  Reset mid-handshake: the block returns to the reset state.
//   The SCK-side importer must be reset by the same event so its ack toggle returns to 0.
//   A reset on this side only is not supported.
//  No X on outputs after reset. wr_data is sampled only when wr_stb=1.
// STRUCTURE
//  Shared package: typedef logic [7:0] byte_t; FSM state enum {IDLE, LOAD, WAIT}.
//   These are shared with the SCK-side importer and the RX exporter.
//  Sub-module: cdc_sync2 (parameterised-width 2-FF synchroniser, async active-low reset), instanced for cdc_ack.
//  FIFO storage and pointers stay inline; no generic FIFO instance.
// TESTING
//  Handshake model: SCK-domain model at an unrelated clock, ratio 1:3.7, echoes cdc_req to cdc_ack after sampling cdc_data.
//  1 Reset: assert rst_n=0 mid-clock -> all outputs at reset values immediately; wr_ready=1, level=0.
//  2 Single byte: write 8'hA5 into empty FIFO.
//    -> cdc_data=A5 after edge N+1, cdc_req 0->1 at N+2.
//    -> model receives A5; FSM back in IDLE after ack_s==1.
//  3 Burst: write 8'h01..8'h08 on consecutive cycles, DEPTH=8.
//    -> all accepted (the first is popped early); model receives 01..08 in order.
//    -> exactly 8 cdc_req toggles.
//  4 Overflow: stall ack, write 10 bytes.
//    -> 1 in flight + 8 buffered; 10th dropped, overflow=1, wr_ready=0.
//    -> ovf_clr pulse with no drop -> overflow=0.
//  5 Simultaneous: full FIFO, pop and wr_stb on the same edge.
//    -> write dropped, overflow=1, level=DEPTH-1.
//    -> separately: push+pop at level 3 -> level stays 3.
//  6 Reset mid-handshake: reset in WAIT with model reset too.
//    -> cdc_req=0, FIFO empty; the next write completes normally with data intact.

Source files
------------

// File: rtl/spi_tx_export_pkg.sv
// Shared definitions for the SPI transmit/receive CDC path.
// The byte type and the exporter FSM encoding are also used by the
// SCK-side importer and the RX exporter, so keep them stable.
package spi_tx_export_pkg;

    typedef logic [7:0] byte_t;

    // Exporter handshake FSM: IDLE waits for data, LOAD settles cdc_data,
    // WAIT holds the request open until the synchronised ack matches.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_tx_export_cdc_sync2.sv
// Two-flop synchroniser for a signal arriving from an unrelated clock.
// Ports:
//   clk   destination clock
//   rst_n asynchronous active-low reset (both stages clear to 0)
//   d     asynchronous input
//   q     synchronised output, two clk edges behind d
// Only use this for single-bit or gray/toggle-coded signals; a multi-bit
// binary value can be captured torn.
module cdc_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Two-stage capture; meta_r may go metastable and is never used directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {W{1'b0}};
            sync_r <= {W{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/spi_tx_export.sv
// System-clock side of the SPI transmit path.
// Bytes written by the peripheral logic are buffered in a small FIFO and
// handed one at a time to the SCK domain over a toggle req/ack handshake.
// Ports:
//   clk       system clock (only clock of this block)
//   rst_n     asynchronous active-low reset
//   wr_stb    write strobe, one byte per cycle
//   wr_data   byte to transmit
//   wr_ready  FIFO not full
//   level     bytes held in the FIFO (0..DEPTH), excluding the byte in flight
//   overflow  sticky: a write was dropped because the FIFO was full
//   ovf_clr   clears overflow (a simultaneous drop wins)
//   cdc_data  byte presented to the SCK domain, stable while handshake open
//   cdc_req   request toggle, flips once per exported byte
//   cdc_ack   ack toggle from the SCK domain, asynchronous to clk
module spi_tx_export
    import spi_tx_export_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_stb,
    input  logic [7:0]    wr_data,
    output logic          wr_ready,
    output logic [LW-1:0] level,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic [7:0]    cdc_data,
    output logic          cdc_req,
    input  logic          cdc_ack
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_EMPTY = {LW{1'b0}};

    byte_t         mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_s;
    logic          wr_ready_r;
    logic          overflow_r;
    byte_t         cdc_data_r;
    logic          cdc_req_r;
    state_t        state_r;
    state_t        state_s;
    logic          ack_s;
    logic          push_s;
    logic          drop_s;
    logic          pop_s;
    logic          toggle_s;

    // Full is judged on the level before this edge, so a pop in the same
    // cycle cannot make room for the incoming byte.
    assign push_s = wr_stb && (level_r != LVL_FULL);
    assign drop_s = wr_stb && (level_r == LVL_FULL);

    cdc_sync2 #(
        .W (1)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cdc_ack),
        .q     (ack_s)
    );

    // Handshake FSM next-state and control strobes.
    always_comb begin
        state_s  = state_r;
        pop_s    = 1'b0;
        toggle_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (level_r != LVL_EMPTY) begin
                    state_s = LOAD;
                    pop_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                state_s  = WAIT;
                toggle_s = 1'b1;
            end
            WAIT: begin
                if (ack_s == cdc_req_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Next FIFO level from push/pop; both together leave it unchanged.
    always_comb begin
        level_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_s = level_r + LW'(1);
            2'b01:   level_s = level_r - LW'(1);
            default: level_s = level_r;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FIFO storage; contents are only ever read after being written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // FIFO pointers (wrap modulo DEPTH), level and registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= LVL_EMPTY;
            wr_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r    <= level_s;
            wr_ready_r <= (level_s != LVL_FULL);
        end
    end

    // Sticky overflow; a drop in the same cycle as ovf_clr keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr) begin
            overflow_r <= 1'b0;
        end
    end

    // Export registers: data is loaded one cycle before the request flips,
    // and is held through the open handshake and beyond when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdc_data_r <= 8'h00;
            cdc_req_r  <= 1'b0;
        end else begin
            if (pop_s) begin
                cdc_data_r <= mem_r[rd_ptr_r];
            end
            if (toggle_s) begin
                cdc_req_r <= ~cdc_req_r;
            end
        end
    end

    assign wr_ready = wr_ready_r;
    assign level    = level_r;
    assign overflow = overflow_r;
    assign cdc_data = cdc_data_r;
    assign cdc_req  = cdc_req_r;

endmodule

// File: tb/tb_spi_tx_export.sv
// Bench for spi_tx_export: transaction-level model of the FIFO and the
// export handshake, checked against the DUT every clk cycle, plus an
// SCK-domain importer model at a 1:3.7 clock ratio that echoes the request.
module tb_spi_tx_export;
    import spi_tx_export_pkg::*;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk     = 1'b0;
    logic          sck     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          wr_stb  = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          ovf_clr = 1'b0;
    logic          cdc_ack = 1'b0;
    logic          wr_ready;
    logic [LW-1:0] level;
    logic          overflow;
    logic [7:0]    cdc_data;
    logic          cdc_req;

    int compared   = 0;
    int mismatched = 0;

    spi_tx_export #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_stb   (wr_stb),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .cdc_data (cdc_data),
        .cdc_req  (cdc_req),
        .cdc_ack  (cdc_ack)
    );

    // clk rises at even times (10 + 20k); sck period 74 rises at odd times,
    // so the two domains never share an edge.
    always #10 clk = ~clk;
    initial begin
        #3;
        forever begin
            sck = 1'b1; #37;
            sck = 1'b0; #37;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    byte_t m_q[$];        // bytes buffered
    byte_t exp_q[$];      // bytes handed over, awaiting import
    byte_t rx_log[$];     // everything the importer captured
    byte_t m_data = 8'h00;
    logic  m_req = 1'b0, m_ovf = 1'b0;
    logic  m_load = 1'b0, m_wait = 1'b0;   // byte just loaded / request open
    logic  m_a1 = 1'b0, m_a2 = 1'b0;       // ack as seen by clk side
    bit    b_full, b_nonempty, b_ack_seen;
    bit    cmp_en = 1'b0;
    logic  stall = 1'b0;
    int    req_toggles = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete(); exp_q.delete();
            m_data = 8'h00; m_req = 1'b0; m_ovf = 1'b0;
            m_load = 1'b0; m_wait = 1'b0; m_a1 = 1'b0; m_a2 = 1'b0;
        end else begin
            b_full     = (m_q.size() == DEPTH);
            b_nonempty = (m_q.size() > 0);
            b_ack_seen = m_a2;
            m_a2 = m_a1;
            m_a1 = cdc_ack;
            if (m_load) begin
                m_req  = ~m_req;
                m_load = 1'b0;
                m_wait = 1'b1;
            end else if (m_wait) begin
                if (b_ack_seen == m_req) m_wait = 1'b0;
            end else if (b_nonempty) begin
                m_data = m_q.pop_front();
                exp_q.push_back(m_data);
                m_load = 1'b1;
            end
            if (wr_stb && !b_full) m_q.push_back(wr_data);
            if (ovf_clr) m_ovf = 1'b0;
            if (wr_stb && b_full) m_ovf = 1'b1;
        end
    end

    // SCK-domain importer: sync the request, capture data, echo the toggle.
    logic k_s1 = 1'b0, k_s2 = 1'b0;
    initial forever begin
        @(posedge sck or negedge rst_n);
        if (!rst_n) begin
            k_s1 = 1'b0; k_s2 = 1'b0; cdc_ack = 1'b0;
        end else begin
            k_s2 = k_s1;
            k_s1 = cdc_req;
            if (!stall && (k_s2 != cdc_ack)) begin
                rx_log.push_back(cdc_data);
                chk("rx_expected_pending", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("rx_byte", cdc_data, exp_q.pop_front());
                cdc_ack = k_s2;
            end
        end
    end

    initial forever begin
        @(cdc_req);
        req_toggles++;
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("level",    level,    m_q.size());
            chk("wr_ready", wr_ready, int'(m_q.size() < DEPTH));
            chk("overflow", overflow, m_ovf);
            chk("cdc_data", cdc_data, m_data);
            chk("cdc_req",  cdc_req,  m_req);
        end
    end

    // ---------------- stimulus helpers (called at negedge clk) ----------------
    task automatic wr(input byte_t d);
        wr_stb  = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_stb  = 1'b0;
    endtask

    task automatic pulse_clr();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int done = 0;
        for (int i = 0; i < budget; i++) begin
            if (m_q.size() == 0 && !m_load && !m_wait && exp_q.size() == 0) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        chk("drain_done", done, 1);
    endtask

    // Write on exactly the edge at which the FIFO pops its head.
    task automatic wr_on_pop(input byte_t d, input int budget);
        int found = 0;
        for (int i = 0; i < budget; i++) begin
            if (!m_load && !m_wait && m_q.size() > 0) begin
                found = 1;
                wr(d);
                break;
            end
            @(negedge clk);
        end
        chk("pop_edge_found", found, 1);
    endtask

    task automatic reset_release();
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int rx0;
        int t0;
        int found;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1);
    end

    initial begin
        int rx0;
        int t0;
        int found;

        // ---- 1: reset ----
        @(negedge clk);
        #3 rst_n = 1'b0;
        cmp_en = 1'b1;
        #1;
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_level",    level,    0);
        chk("rst_overflow", overflow, 0);
        chk("rst_cdc_req",  cdc_req,  0);
        chk("rst_cdc_data", cdc_data, 8'h00);
        reset_release();

        // mid-clock reset after a byte has been loaded
        wr(8'h5A);
        @(negedge clk);
        chk("pre_rst_cdc_data", cdc_data, 8'h5A);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_cdc_data", cdc_data, 8'h00);
        chk("midrst_level",    level,    0);
        chk("midrst_wr_ready", wr_ready, 1);
        reset_release();

        // ---- 2: single byte latency ----
        rx0 = rx_log.size();
        wr(8'hA5);                       // edge N
        chk("n0_level",   level,   1);
        chk("n0_cdc_req", cdc_req, 0);
        @(negedge clk);                  // after N+1
        chk("n1_cdc_data", cdc_data, 8'hA5);
        chk("n1_cdc_req",  cdc_req,  0);
        chk("n1_level",    level,    0);
        @(negedge clk);                  // after N+2
        chk("n2_cdc_req", cdc_req, 1);
        wait_drain(400);
        chk("single_rx_count", rx_log.size() - rx0, 1);
        if (rx_log.size() > rx0) chk("single_rx_byte", rx_log[rx0], 8'hA5);

        // ---- 3: burst 01..08 ----
        rx0 = rx_log.size();
        t0  = req_toggles;
        for (int i = 1; i <= 8; i++) wr(byte_t'(i));
        chk("burst_no_ovf", overflow, 0);
        wait_drain(1000);
        chk("burst_toggles", req_toggles - t0, 8);
        chk("burst_rx_count", rx_log.size() - rx0, 8);
        for (int i = 1; i <= 8; i++)
            if (rx_log.size() >= rx0 + i) chk("burst_rx_byte", rx_log[rx0+i-1], i);

        // ---- 4: overflow with stalled ack ----
        stall = 1'b1;
        for (int i = 0; i < 10; i++) wr(byte_t'(8'h10 + i));
        chk("ovf_set",       overflow, 1);
        chk("ovf_wr_ready",  wr_ready, 0);
        chk("ovf_level",     level,    8);
        chk("model_level",   m_q.size(), 8);
        chk("model_inflight", m_data, 8'h10);
        pulse_clr();
        chk("ovf_cleared", overflow, 0);

        // ---- 5a: full FIFO, write on the popping edge is dropped ----
        stall = 1'b0;
        wr_on_pop(8'hEE, 400);
        chk("simul_ovf",   overflow, 1);
        chk("simul_level", level,    DEPTH - 1);
        wait_drain(1000);
        pulse_clr();

        // ---- 5b: push+pop at level 3 ----
        stall = 1'b1;
        for (int i = 0; i < 4; i++) wr(byte_t'(8'h40 + i));
        chk("l3_level_before", level, 3);
        stall = 1'b0;
        wr_on_pop(8'h77, 400);
        chk("l3_level_after", level, 3);
        wait_drain(1000);

        // ---- 6: reset in WAIT ----
        stall = 1'b1;
        wr(8'h99);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_wait) begin found = 1; break; end
            @(negedge clk);
        end
        chk("reached_wait", found, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("wait_rst_req",   cdc_req, 0);
        chk("wait_rst_level", level,   0);
        chk("wait_rst_ready", wr_ready, 1);
        reset_release();
        stall = 1'b0;
        rx0 = rx_log.size();
        wr(8'h3C);
        wait_drain(400);
        chk("post_rst_rx_count", rx_log.size() - rx0, 1);
        if (rx_log.size() > rx0) chk("post_rst_rx_byte", rx_log[rx0], 8'h3C);

        // ---- random traffic ----
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) stall = ~stall;
            wr_stb  = ($urandom_range(0, 2) == 0);
            wr_data = 8'($urandom);
            ovf_clr = ($urandom_range(0, 19) == 0);
            @(negedge clk);
        end
        wr_stb  = 1'b0;
        ovf_clr = 1'b0;
        stall   = 1'b0;
        wait_drain(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
